ahb_resp_mux: RTL
=================

// Module: ahb_resp_mux
// PURPOSE
//   Data-phase response multiplexer for the AHB interconnect, directly downstream of the address decoder.
//   - Registers the decoder's one-hot Hsel at each accepted address phase.
//   - Routes the owning slave's Hrdata/Hreadyout/Hresp back to the master during the following data phase.
//   - Contains a built-in default slave that returns the two-cycle AHB ERROR response for unmapped transfers.
// PARAMETERS
//   NUM_SLAVES  3   number of slaves; width of Hsel, matches the decoder's slave count
//   DATA_WIDTH  32  read data width
// PORTS
//   Hclk         in   1                      bus clock; all state updates on rising edge
//   Hreset       in   1                      reset: one clock; reset is asynchronous and active-high
//   Hsel         in   NUM_SLAVES             one-hot slave select from decoder (address phase)
//   Htrans       in   2                      master transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   Hrdata_s     in   NUM_SLAVES*DATA_WIDTH  slave read data; slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   Hreadyout_s  in   NUM_SLAVES             per-slave ready
//   Hresp_s      in   NUM_SLAVES             per-slave response: 0 OKAY, 1 ERROR
//   Hrdata       out  DATA_WIDTH             read data to master
//   Hready       out  1                      bus ready to master and all slaves
//   Hresp        out  1                      response to master
//   Hsel_dp      out  NUM_SLAVES             registered data-phase owner, one-hot; all-zero = none/default
// BEHAVIOUR
//   - Address-phase acceptance: on a rising edge where Hready==1.
//     While Hready==0, Hsel and Htrans are ignored and all registered state holds.
//   - Owner capture (at an accepted edge):
//     - Htrans[1]==0 (IDLE/BUSY): owner = NONE.
//     - Htrans[1]==1 and Hsel!=0: owner = SLAVE[i], where i is the lowest set bit of Hsel.
//     - Htrans[1]==1 and Hsel==0: owner = DEFAULT; FSM enters ERR1.
//   - Output muxing (combinational from the registered owner and FSM state):
//     - SLAVE[i]: Hrdata = Hrdata_s[i], Hready = Hreadyout_s[i], Hresp = Hresp_s[i].
//     - NONE: Hrdata = 0, Hready = 1, Hresp = 0 (zero-wait OKAY).
//     - DEFAULT: Hrdata = 0; Hready and Hresp come from the default-slave FSM.
//   - Default-slave FSM states: IDLE, ERR1, ERR2.
//     - IDLE -> ERR1 on an accepted unmapped NONSEQ/SEQ.
//     - ERR1: Hready = 0, Hresp = 1. Always -> ERR2 on the next edge.
//     - ERR2: Hready = 1, Hresp = 1. The next address phase is accepted on this edge.
//       -> ERR1 if that address is again unmapped and active; otherwise -> IDLE.
//   - Latency:
//     - Response appears in the cycle after the accepted address phase.
//     - A mapped zero-wait slave completes in 1 cycle; an unmapped transfer takes exactly 2 data-phase cycles.
//   - Wait states: a slave holding Hreadyout_s[i] = 0 keeps owner SLAVE[i] and keeps Hready = 0.
//     No new address phase is accepted until the slave releases Hreadyout_s[i].
//   - A slave ERROR response (Hresp_s = 1) passes through unmodified, including its two-cycle form.
//   - Back-to-back transfers: the owner may change on every accepted edge, e.g. slave0 -> slave2 -> unmapped -> slave1.
//   - Reset values (asserted asynchronously, output visible immediately):
//     owner = NONE, FSM = IDLE, Hsel_dp = 0, Hready = 1, Hresp = 0, Hrdata = 0.
//   - Reset mid-ERR1 or mid-wait: Hready returns to 1 immediately. The pending transfer is dropped.
//   - Hsel_dp = one-hot of the owner for SLAVE[i]; 0 for NONE and DEFAULT.
// TESTING
//   1. Reset: assert Hreset mid-cycle
//      -> Hready = 1, Hresp = 0, Hrdata = 0, Hsel_dp = 0 without waiting for a clock edge.
//   2. NONSEQ, Hsel = 3'b010, Hrdata_s[1] = 32'hDEAD_BEEF, Hreadyout_s[1] = 1
//      -> next cycle: Hrdata = 32'hDEAD_BEEF, Hready = 1, Hresp = 0, Hsel_dp = 3'b010.
//   3. NONSEQ, Hsel = 3'b000
//      -> cycle+1: Hready = 0, Hresp = 1; cycle+2: Hready = 1, Hresp = 1; cycle+3 (IDLE issued): Hready = 1, Hresp = 0.
//   4. Slave 2 holds Hreadyout_s[2] = 0 for 3 cycles while Hsel/Htrans toggle
//      -> Hready = 0 for 3 cycles, Hsel_dp stays 3'b100, and the address issued during the stall is not captured.
//   5. Back-to-back: unmapped NONSEQ then slave0 NONSEQ issued during ERR2
//      -> 2-cycle ERROR, then the slave0 response in the following cycle with Hsel_dp = 3'b001.
//   6. IDLE with Hsel = 3'b001 -> next cycle: Hsel_dp = 0, Hready = 1, Hresp = 0.
//      Hsel = 3'b011 with NONSEQ -> Hsel_dp = 3'b001 (lowest index wins).

Source files
------------

// File: rtl/ahb_resp_mux.sv
// AHB data-phase response multiplexer: captures the decoder's one-hot select on each
// accepted address phase and returns the owning slave's response, or a two-cycle ERROR for unmapped transfers.
module ahb_resp_mux #(
    parameter int NUM_SLAVES = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             Hclk,
    input  logic                             Hreset,
    input  logic [NUM_SLAVES-1:0]            Hsel,
    input  logic [1:0]                       Htrans,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] Hrdata_s,
    input  logic [NUM_SLAVES-1:0]            Hreadyout_s,
    input  logic [NUM_SLAVES-1:0]            Hresp_s,
    output logic [DATA_WIDTH-1:0]            Hrdata,
    output logic                             Hready,
    output logic                             Hresp,
    output logic [NUM_SLAVES-1:0]            Hsel_dp
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    ds_state_e               state_q, state_d;
    logic [NUM_SLAVES-1:0]   owner_q, owner_d;
    logic [DATA_WIDTH-1:0]   hrdata_mux;
    logic                    hready_mux;
    logic                    hresp_mux;

    // Keeps only the lowest set bit, so a malformed multi-hot select still yields one owner.
    function automatic logic [NUM_SLAVES-1:0] lowest_onehot(input logic [NUM_SLAVES-1:0] sel);
        logic [NUM_SLAVES-1:0] res;
        res = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (sel[i]) begin
                res    = '0;
                res[i] = 1'b1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Owner and default-slave state registers.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q <= DS_IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Next owner / default-slave state; the address phase is only sampled when the bus is ready.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (state_q == DS_ERR1) begin
            state_d = DS_ERR2;
            owner_d = '0;
        end else if (hready_mux) begin
            if (!Htrans[1]) begin
                state_d = DS_IDLE;
                owner_d = '0;
            end else if (Hsel != '0) begin
                state_d = DS_IDLE;
                owner_d = lowest_onehot(Hsel);
            end else begin
                state_d = DS_ERR1;
                owner_d = '0;
            end
        end else begin
            state_d = state_q;
            owner_d = owner_q;
        end
    end

    // Data-phase response mux; an all-zero owner outside the error sequence is a zero-wait OKAY.
    always_comb begin
        hrdata_mux = '0;
        hready_mux = 1'b1;
        hresp_mux  = 1'b0;
        case (state_q)
            DS_ERR1: begin
                hready_mux = 1'b0;
                hresp_mux  = 1'b1;
            end
            DS_ERR2: begin
                hready_mux = 1'b1;
                hresp_mux  = 1'b1;
            end
            default: begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (owner_q[i]) begin
                        hrdata_mux = Hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
                        hready_mux = Hreadyout_s[i];
                        hresp_mux  = Hresp_s[i];
                    end else begin
                        hrdata_mux = hrdata_mux;
                    end
                end
            end
        endcase
    end

    assign Hrdata  = hrdata_mux;
    assign Hready  = hready_mux;
    assign Hresp   = hresp_mux;
    assign Hsel_dp = owner_q;

endmodule
